// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: instruction-memory and decode handshake bundle for pc_sequencer.
// The master modport is the sequencer. The slave modport is the surrounding
// core: instruction memory, decode/control and the redirect sources.
`timescale 1ns/1ps
interface pc_sequencer_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               halt;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic               jmp;
  logic [PC_W-1:0]    jmp_target;
  logic               br_taken;
  logic [PC_W-1:0]    br_offset;
  logic               flush;
  logic [PC_W-1:0]    flush_target;
  logic [15:0]        retired_cnt;

  modport master (
    input  halt, imem_ack, imem_rdata, instr_ready, jmp, jmp_target,
           br_taken, br_offset, flush, flush_target,
    output imem_req, imem_addr, instr, instr_pc, instr_valid, retired_cnt
  );

  modport slave (
    output halt, imem_ack, imem_rdata, instr_ready, jmp, jmp_target,
           br_taken, br_offset, flush, flush_target,
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, retired_cnt
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch / program-counter controller.
// Owns the PC and fetches one instruction at a time over a req/ack memory
// port. It holds each instruction for decode until it is accepted, then
// computes the next PC from the jump/branch redirect inputs.
// A FETCH cycle with imem_req low is the request set-up slot. It also serves
// as the one-cycle gap after a killed request.
// Optional feature macro: PC_ALIGN_TRAP_EN. It adds the align_trap output and
// the TRAP_VEC parameter. Odd next-PC or flush targets are then replaced by
// TRAP_VEC.
`timescale 1ns/1ps
module pc_sequencer #(
  parameter int              PC_W      = 16,
  parameter int              INSTR_W   = 16,
  parameter logic [PC_W-1:0] RESET_VEC = 16'h0000,
  parameter int              PC_STEP   = 2
`ifdef PC_ALIGN_TRAP_EN
  ,
  parameter logic [PC_W-1:0] TRAP_VEC  = 16'h0004
`endif
) (
  input  logic           clk,
  input  logic           rst,
`ifdef PC_ALIGN_TRAP_EN
  output logic           align_trap,
`endif
  pc_sequencer_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  localparam logic [PC_W-1:0] STEP_C = PC_W'(PC_STEP);

  logic [1:0]         state_r, state_s;
  logic [PC_W-1:0]    pc_r, pc_s;
  logic [PC_W-1:0]    addr_r, addr_s;
  logic               req_r, req_s;
  logic               kill_r, kill_s;
  logic [INSTR_W-1:0] instr_r, instr_s;
  logic [PC_W-1:0]    instr_pc_r, instr_pc_s;
  logic               valid_r, valid_s;
  logic [15:0]        cnt_r, cnt_s;

  logic               accept_s;
  logic [PC_W-1:0]    raw_next_s;
  logic [PC_W-1:0]    accept_next_s;
  logic [PC_W-1:0]    flush_next_s;

  assign accept_s = (state_r == ST_HOLD) & valid_r & bus.instr_ready;

  // Redirect target on accept: jump beats branch, branch beats sequential.
  always_comb begin
    if (bus.jmp) begin
      raw_next_s = bus.jmp_target;
    end else if (bus.br_taken) begin
      raw_next_s = instr_pc_r + (bus.br_offset << 1);
    end else begin
      raw_next_s = instr_pc_r + STEP_C;
    end
  end

`ifdef PC_ALIGN_TRAP_EN
  logic align_trap_r;
  logic trap_s;

  function automatic logic [PC_W-1:0] align_fix(input logic [PC_W-1:0] a);
    return a[0] ? TRAP_VEC : a;
  endfunction

  assign accept_next_s = align_fix(raw_next_s);
  assign flush_next_s  = align_fix(bus.flush_target);
  assign trap_s        = bus.flush ? bus.flush_target[0] : (accept_s & raw_next_s[0]);
  assign align_trap    = align_trap_r;

  // One-cycle trap pulse whenever an odd target gets redirected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_trap_r <= 1'b0;
    end else begin
      align_trap_r <= trap_s;
    end
  end
`else
  assign accept_next_s = raw_next_s;
  assign flush_next_s  = bus.flush_target;
`endif

  // Next-state logic. Flush only retargets the PC and never disturbs a request
  // already on the bus. A killed request drains, then goes through the gap slot.
  always_comb begin
    state_s    = state_r;
    pc_s       = bus.flush ? flush_next_s : pc_r;
    addr_s     = addr_r;
    req_s      = req_r;
    kill_s     = kill_r;
    instr_s    = instr_r;
    instr_pc_s = instr_pc_r;
    valid_s    = valid_r;
    cnt_s      = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.halt) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (!req_r) begin
          req_s  = 1'b1;
          addr_s = pc_s;
        end else if (bus.imem_ack) begin
          req_s = 1'b0;
          if (kill_r || bus.flush) begin
            kill_s = 1'b0;
          end else begin
            instr_s    = bus.imem_rdata;
            instr_pc_s = addr_r;
            valid_s    = 1'b1;
            state_s    = ST_HOLD;
          end
        end else begin
          kill_s = kill_r | bus.flush;
        end
      end
      ST_HOLD: begin
        if (bus.flush) begin
          valid_s = 1'b0;
          state_s = bus.halt ? ST_IDLE : ST_FETCH;
        end else if (accept_s) begin
          valid_s = 1'b0;
          cnt_s   = cnt_r + 16'd1;
          pc_s    = accept_next_s;
          state_s = bus.halt ? ST_IDLE : ST_FETCH;
        end else begin
          valid_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
        req_s   = 1'b0;
        kill_s  = 1'b0;
        valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers. Reset parks the block idle with an empty pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pc_r       <= RESET_VEC;
      addr_r     <= RESET_VEC;
      req_r      <= 1'b0;
      kill_r     <= 1'b0;
      instr_r    <= '0;
      instr_pc_r <= '0;
      valid_r    <= 1'b0;
      cnt_r      <= 16'd0;
    end else begin
      state_r    <= state_s;
      pc_r       <= pc_s;
      addr_r     <= addr_s;
      req_r      <= req_s;
      kill_r     <= kill_s;
      instr_r    <= instr_s;
      instr_pc_r <= instr_pc_s;
      valid_r    <= valid_s;
      cnt_r      <= cnt_s;
    end
  end

  assign bus.imem_req    = req_r;
  assign bus.imem_addr   = addr_r;
  assign bus.instr       = instr_r;
  assign bus.instr_pc    = instr_pc_r;
  assign bus.instr_valid = valid_r;
  assign bus.retired_cnt = cnt_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer.
// Table-driven redirect vectors, hand-written multi-cycle sequences, and a
// randomized run checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_pc_sequencer;
  localparam logic [15:0] RESET_VEC = 16'h0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  pc_sequencer_if #(.PC_W(16), .INSTR_W(16)) bus ();
`ifdef PC_ALIGN_TRAP_EN
  logic align_trap;
`endif

  pc_sequencer #(.PC_W(16), .INSTR_W(16), .RESET_VEC(RESET_VEC), .PC_STEP(2)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PC_ALIGN_TRAP_EN
    .align_trap(align_trap),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Expected target after optional odd-address trapping
  function automatic logic [15:0] fix(input logic [15:0] a);
`ifdef PC_ALIGN_TRAP_EN
    return a[0] ? 16'h0004 : a;
`else
    return a;
`endif
  endfunction

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] ipc, input logic j,
      input logic [15:0] jt, input logic b, input logic [15:0] bo);
    logic [15:0] r;
    if (j) r = jt;
    else if (b) r = ipc + bo * 16'd2;
    else r = ipc + 16'd2;
    return fix(r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.halt = 1'b0; bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0000;
    bus.instr_ready = 1'b0; bus.jmp = 1'b0; bus.jmp_target = 16'h0000;
    bus.br_taken = 1'b0; bus.br_offset = 16'h0000;
    bus.flush = 1'b0; bus.flush_target = 16'h0000;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!bus.imem_req && n < 40) begin
      tick();
      n++;
    end
    chk1(nm, bus.imem_req, 1'b1);
  endtask

  typedef struct {
    logic [15:0] start_pc;
    logic        jmp;
    logic [15:0] jt;
    logic        br;
    logic [15:0] bo;
    logic [15:0] exp_next;
  } vec_t;
  vec_t vecs[8];

  logic [15:0] m_pc, m_cnt, m_raddr, m_ins, m_ipc;
  logic        m_hold, m_kill, m_open;
  int          dly;
  int          n;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h0010, 1'b1, 16'h0100, 1'b1, 16'h0004, 16'h0100};
    vecs[1] = '{16'h0010, 1'b0, 16'h0000, 1'b1, 16'hFFFC, 16'h0008};
    vecs[2] = '{16'hFFFE, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{16'h0010, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0012};
    vecs[4] = '{16'h0010, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h0016};
    vecs[5] = '{16'hFFF0, 1'b0, 16'h0000, 1'b1, 16'h0010, 16'h0010};
    vecs[6] = '{16'h1234, 1'b1, 16'h2000, 1'b0, 16'h0000, 16'h2000};
    vecs[7] = '{16'h0020, 1'b1, 16'h0101, 1'b0, 16'h0000, fix(16'h0101)};

    // Reset state
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    chk1("rst_req", bus.imem_req, 1'b0);
    chk("rst_addr", bus.imem_addr, RESET_VEC);
    chk("rst_instr", bus.instr, 16'h0000);
    chk("rst_ipc", bus.instr_pc, 16'h0000);
    chk1("rst_valid", bus.instr_valid, 1'b0);
    chk("rst_cnt", bus.retired_cnt, 16'h0000);
    rst = 1'b0;

    // First fetch, acked the cycle after the request
    bus.instr_ready = 1'b1;
    wait_req("a_req0");
    chk("a_addr0", bus.imem_addr, 16'h0000);
    tick();
    chk("a_addr_hold", bus.imem_addr, 16'h0000);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hA001;
    tick();
    bus.imem_ack = 1'b0;
    chk1("a_valid", bus.instr_valid, 1'b1);
    chk("a_instr", bus.instr, 16'hA001);
    chk("a_ipc", bus.instr_pc, 16'h0000);
    tick();
    chk1("a_valid_drop", bus.instr_valid, 1'b0);
    chk("a_cnt", bus.retired_cnt, 16'd1);
    wait_req("a_req1");
    chk("a_addr1", bus.imem_addr, 16'h0002);
    // Back-to-back throughput: same-cycle ack, immediate ready -> 3 cycles
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1111;
    n = 0;
    do begin
      tick();
      bus.imem_ack = 1'b0;
      n++;
    end while (!bus.imem_req && n < 10);
    chk("a_period", 16'(n), 16'd3);
    chk("a_addr2", bus.imem_addr, 16'h0004);
    chk("a_cnt2", bus.retired_cnt, 16'd2);
    bus.instr_ready = 1'b0;

    // Redirect vectors
    for (int i = 0; i < 8; i++) begin
      do_reset();
      bus.flush = 1'b1; bus.flush_target = vecs[i].start_pc;
      tick();
      bus.flush = 1'b0;
      wait_req($sformatf("v%0d_req0", i));
      chk($sformatf("v%0d_addr0", i), bus.imem_addr, vecs[i].start_pc);
      bus.imem_ack = 1'b1; bus.imem_rdata = mem_word(vecs[i].start_pc);
      tick();
      bus.imem_ack = 1'b0;
      chk1($sformatf("v%0d_valid", i), bus.instr_valid, 1'b1);
      chk($sformatf("v%0d_ipc", i), bus.instr_pc, vecs[i].start_pc);
      bus.instr_ready = 1'b1;
      bus.jmp = vecs[i].jmp; bus.jmp_target = vecs[i].jt;
      bus.br_taken = vecs[i].br; bus.br_offset = vecs[i].bo;
      tick();
      set_idle();
      chk($sformatf("v%0d_cnt", i), bus.retired_cnt, 16'd1);
      wait_req($sformatf("v%0d_req1", i));
      chk($sformatf("v%0d_next", i), bus.imem_addr, vecs[i].exp_next);
    end

    // Flush with a request outstanding; ack three cycles later
    do_reset();
    bus.flush = 1'b1; bus.flush_target = 16'h0008;
    tick();
    bus.flush = 1'b0;
    wait_req("b_req0");
    chk("b_addr0", bus.imem_addr, 16'h0008);
    bus.flush = 1'b1; bus.flush_target = 16'h0040;
    for (int k = 1; k <= 3; k++) begin
      tick();
      bus.flush = 1'b0;
      chk1($sformatf("b_req_hold%0d", k), bus.imem_req, 1'b1);
      chk($sformatf("b_addr_hold%0d", k), bus.imem_addr, 16'h0008);
      chk1($sformatf("b_novalid%0d", k), bus.instr_valid, 1'b0);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
    tick();
    bus.imem_ack = 1'b0;
    chk1("b_gap_req", bus.imem_req, 1'b0);
    chk1("b_gap_valid", bus.instr_valid, 1'b0);
    tick();
    chk1("b_req1", bus.imem_req, 1'b1);
    chk("b_addr1", bus.imem_addr, 16'h0040);
    chk1("b_valid1", bus.instr_valid, 1'b0);
    chk("b_cnt", bus.retired_cnt, 16'd0);

    // Stall in HOLD, then accept with halt and park in IDLE
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBEEF;
    tick();
    bus.imem_ack = 1'b0;
    chk1("c_valid", bus.instr_valid, 1'b1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("c_instr%0d", k), bus.instr, 16'hBEEF);
      chk($sformatf("c_ipc%0d", k), bus.instr_pc, 16'h0040);
      chk1($sformatf("c_valid%0d", k), bus.instr_valid, 1'b1);
      chk1($sformatf("c_noreq%0d", k), bus.imem_req, 1'b0);
    end
    bus.halt = 1'b1; bus.instr_ready = 1'b1;
    tick();
    bus.instr_ready = 1'b0;
    chk1("c_valid_drop", bus.instr_valid, 1'b0);
    chk("c_cnt", bus.retired_cnt, 16'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1($sformatf("c_halt_noreq%0d", k), bus.imem_req, 1'b0);
    end
    bus.halt = 1'b0;
    wait_req("c_req");
    chk("c_addr", bus.imem_addr, 16'h0042);

    // Asynchronous reset while a request is outstanding
    #2;
    rst = 1'b1;
    #1;
    chk1("d_req_async", bus.imem_req, 1'b0);
    chk1("d_valid_async", bus.instr_valid, 1'b0);
    chk("d_cnt_async", bus.retired_cnt, 16'd0);
    tick();
    rst = 1'b0;
    wait_req("d_req");
    chk("d_addr", bus.imem_addr, RESET_VEC);

    // Randomized run against the transaction-level model
    do_reset();
    m_pc = RESET_VEC; m_cnt = 16'd0; m_hold = 1'b0; m_kill = 1'b0;
    m_open = 1'b0; m_raddr = 16'h0000; m_ins = 16'h0000; m_ipc = 16'h0000; dly = 0;
    for (int c = 0; c < 4000; c++) begin
      chk("r_cnt", bus.retired_cnt, m_cnt);
      chk1("r_valid", bus.instr_valid, m_hold);
      if (m_hold) begin
        chk("r_instr", bus.instr, m_ins);
        chk("r_ipc", bus.instr_pc, m_ipc);
      end
      if (bus.imem_req) begin
        if (!m_open) begin
          chk("r_addr", bus.imem_addr, m_pc);
          m_open = 1'b1;
          m_raddr = m_pc;
          dly = $urandom_range(0, 3);
        end else begin
          chk("r_stable", bus.imem_addr, m_raddr);
        end
      end
      bus.imem_ack = bus.imem_req && (dly == 0);
      if (bus.imem_req && dly > 0) dly--;
      bus.imem_rdata   = bus.imem_ack ? mem_word(m_raddr) : 16'($urandom);
      bus.instr_ready  = ($urandom_range(0, 3) != 0);
      bus.jmp          = ($urandom_range(0, 5) == 0);
      bus.jmp_target   = 16'($urandom);
      bus.br_taken     = ($urandom_range(0, 3) == 0);
      bus.br_offset    = 16'($urandom_range(0, 31)) - 16'd16;
      bus.flush        = ($urandom_range(0, 24) == 0);
      bus.flush_target = 16'($urandom);
      bus.halt         = ($urandom_range(0, 9) == 0);

      if (bus.flush) begin
        m_pc = fix(bus.flush_target);
        m_hold = 1'b0;
        if (m_open && !bus.imem_ack) m_kill = 1'b1;
      end else if (m_hold && bus.instr_ready) begin
        m_cnt = m_cnt + 16'd1;
        m_pc = next_pc(m_ipc, bus.jmp, bus.jmp_target, bus.br_taken, bus.br_offset);
        m_hold = 1'b0;
      end
      if (bus.imem_ack) begin
        m_open = 1'b0;
        if (bus.flush || m_kill) begin
          m_kill = 1'b0;
        end else begin
          m_hold = 1'b1;
          m_ins = bus.imem_rdata;
          m_ipc = m_raddr;
        end
      end
      tick();
    end
    chk1("r_progress", (m_cnt > 16'd100), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
